// File: rtl/systolic_matmul_stream.sv
// systolic_matmul_stream: weight-stationary DIM x DIM matrix multiplier, Y = W * X.
//
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   start        job start, sampled only while idle
//   reuse_w      sampled with start; 1 skips the weight load and reuses the stored W
//   VAL_i/RDY_o  operand beat handshake; DATA_i carries a W row or an X column,
//                element k at [(DIM-1-k)*DW +: DW]
//   OUT_o        one Y column per cycle, row j at [(DIM-1-j)*ACCW +: ACCW]
//   VAL_o, OV_o  column valid, and "some element of this column saturated"
//   BUSY_o       not idle; DONE_o is a one-cycle job-complete pulse
//
// Results leave on the schedule of a skewed array: 2*DIM fill cycles, then one column per
// cycle. The MAC grid is evaluated for one X column per cycle, and the column index is
// derived from the compute cycle counter.
module systolic_matmul_stream #(
   parameter int unsigned DIM    = 5,
   parameter int unsigned DW     = 8,
   parameter int unsigned T      = 10,
   parameter int unsigned ACCW   = 2 * DW + $clog2(DIM),
   parameter int unsigned SIGNED = 0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  reuse_w,
   input  logic                  VAL_i,
   input  logic [DIM*DW-1:0]     DATA_i,
   output logic                  RDY_o,
   output logic [DIM*ACCW-1:0]   OUT_o,
   output logic                  VAL_o,
   output logic                  OV_o,
   output logic                  BUSY_o,
   output logic                  DONE_o
);

   // Exact sum width plus one sign bit so signed and unsigned share one datapath.
   localparam int unsigned SW = 2 * DW + $clog2(DIM);
   localparam int unsigned EW = SW + 1;
   localparam int unsigned CW = $clog2(2 * DIM + T + 1);
   localparam int unsigned RW = $clog2(DIM);
   localparam int unsigned XW = (T > 1) ? $clog2(T) : 1;

   localparam logic [CW-1:0] LastRow  = CW'(DIM - 1);
   localparam logic [CW-1:0] LastCol  = CW'(T - 1);
   localparam logic [CW-1:0] FirstOut = CW'(2 * DIM - 1);
   localparam logic [CW-1:0] LastOut  = CW'(2 * DIM + T - 2);
   localparam logic [CW-1:0] LastCyc  = CW'(2 * DIM + T - 1);

   localparam logic signed [EW-1:0] SatHi = (SIGNED != 0) ?
      EW'((64'(1) << (ACCW - 1)) - 64'(1)) : EW'((64'(1) << ACCW) - 64'(1));
   localparam logic signed [EW-1:0] SatLo = (SIGNED != 0) ?
      EW'(64'(0) - (64'(1) << (ACCW - 1))) : EW'(0);

   typedef enum logic [1:0] {StIdle, StLoadW, StLoadX, StCompute} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [DW-1:0]        w_q [DIM][DIM];
   logic [DW-1:0]        w_d [DIM][DIM];
   logic [DW-1:0]        x_q [T][DIM];
   logic [DW-1:0]        x_d [T][DIM];
   logic [DIM*ACCW-1:0]  out_q, out_d;
   logic                 val_q, val_d;
   logic                 ov_q, ov_d;
   logic                 done_q, done_d;

   logic                 in_win;
   logic [XW-1:0]        col_sel;
   logic signed [EW-1:0] acc;
   logic signed [EW-1:0] sat_y;
   logic [DIM*ACCW-1:0]  col_y;
   logic                 col_ov;

   function automatic logic signed [EW-1:0] ext(input logic [DW-1:0] v);
      if (SIGNED != 0) return EW'($signed(v));
      return EW'(v);
   endfunction

   // Column t is registered during compute cycle 2*DIM-1+t so it is visible at 2*DIM+t.
   always_comb begin
      in_win  = (cnt_q >= FirstOut) && (cnt_q <= LastOut);
      col_sel = in_win ? XW'(cnt_q - FirstOut) : '0;
      col_y   = '0;
      col_ov  = 1'b0;
      acc     = '0;
      sat_y   = '0;
      for (int j = 0; j < int'(DIM); j++) begin
         acc = '0;
         for (int k = 0; k < int'(DIM); k++) begin
            acc = acc + ext(w_q[j][k]) * ext(x_q[col_sel][k]);
         end
         if (acc > SatHi) begin
            sat_y  = SatHi;
            col_ov = 1'b1;
         end else if (acc < SatLo) begin
            sat_y  = SatLo;
            col_ov = 1'b1;
         end else begin
            sat_y  = acc;
         end
         col_y[(DIM-1-j)*ACCW +: ACCW] = ACCW'(sat_y);
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      x_d     = x_q;
      out_d   = out_q;
      val_d   = 1'b0;
      ov_d    = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = reuse_w ? StLoadX : StLoadW;
               cnt_d   = '0;
            end
         end
         StLoadW: begin
            if (VAL_i) begin
               for (int k = 0; k < int'(DIM); k++) begin
                  w_d[cnt_q[RW-1:0]][k] = DATA_i[(DIM-1-k)*DW +: DW];
               end
               if (cnt_q == LastRow) begin
                  cnt_d   = '0;
                  state_d = StLoadX;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StLoadX: begin
            if (VAL_i) begin
               for (int k = 0; k < int'(DIM); k++) begin
                  x_d[cnt_q[XW-1:0]][k] = DATA_i[(DIM-1-k)*DW +: DW];
               end
               if (cnt_q == LastCol) begin
                  cnt_d   = '0;
                  state_d = StCompute;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         StCompute: begin
            cnt_d = cnt_q + CW'(1);
            if (in_win) begin
               out_d = col_y;
               val_d = 1'b1;
               ov_d  = col_ov;
            end
            if (cnt_q == LastCyc) begin
               done_d  = 1'b1;
               cnt_d   = '0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         w_q     <= '{default: '0};
         x_q     <= '{default: '0};
         out_q   <= '0;
         val_q   <= 1'b0;
         ov_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         x_q     <= x_d;
         out_q   <= out_d;
         val_q   <= val_d;
         ov_q    <= ov_d;
         done_q  <= done_d;
      end
   end

   assign RDY_o  = (state_q == StLoadW) || (state_q == StLoadX);
   assign BUSY_o = (state_q != StIdle);
   assign OUT_o  = out_q;
   assign VAL_o  = val_q;
   assign OV_o   = ov_q;
   assign DONE_o = done_q;

endmodule

// File: tb/tb_systolic_matmul_stream.sv
// Bench for systolic_matmul_stream: three instances share one stimulus stream
// (unsigned ACCW=19, signed ACCW=16, unsigned ACCW=16). A driver issues jobs and pushes the
// expected columns into per-instance queues; a negedge monitor pops and compares.
module tb_systolic_matmul_stream;
   localparam int DIM = 5;
   localparam int DW  = 8;
   localparam int T   = 10;
   localparam int AW0 = 19;
   localparam int AW1 = 16;
   localparam int AW2 = 16;

   typedef struct {
      longint y[DIM];
      bit     ov;
   } col_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic start = 1'b0;
   logic reuse_w = 1'b0;
   logic VAL_i = 1'b0;
   logic [DIM*DW-1:0] DATA_i = '0;
   logic [2:0] rdy, val, ov, busy, done;
   logic [DIM*AW0-1:0] out0;
   logic [DIM*AW1-1:0] out1;
   logic [DIM*AW2-1:0] out2;

   systolic_matmul_stream #(.DIM(DIM), .DW(DW), .T(T), .ACCW(AW0), .SIGNED(0)) u_dut0 (
      .CLK(CLK), .RST(RST), .start(start), .reuse_w(reuse_w), .VAL_i(VAL_i), .DATA_i(DATA_i),
      .RDY_o(rdy[0]), .OUT_o(out0), .VAL_o(val[0]), .OV_o(ov[0]), .BUSY_o(busy[0]),
      .DONE_o(done[0]));
   systolic_matmul_stream #(.DIM(DIM), .DW(DW), .T(T), .ACCW(AW1), .SIGNED(1)) u_dut1 (
      .CLK(CLK), .RST(RST), .start(start), .reuse_w(reuse_w), .VAL_i(VAL_i), .DATA_i(DATA_i),
      .RDY_o(rdy[1]), .OUT_o(out1), .VAL_o(val[1]), .OV_o(ov[1]), .BUSY_o(busy[1]),
      .DONE_o(done[1]));
   systolic_matmul_stream #(.DIM(DIM), .DW(DW), .T(T), .ACCW(AW2), .SIGNED(0)) u_dut2 (
      .CLK(CLK), .RST(RST), .start(start), .reuse_w(reuse_w), .VAL_i(VAL_i), .DATA_i(DATA_i),
      .RDY_o(rdy[2]), .OUT_o(out2), .VAL_o(val[2]), .OV_o(ov[2]), .BUSY_o(busy[2]),
      .DONE_o(done[2]));

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;
   int model_w[DIM][DIM];
   int model_x[DIM][T];
   col_t q0[$];
   col_t q1[$];
   col_t q2[$];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d required=%0d at %0t", name, got, exp, $time);
      end
   endtask

   function automatic longint sx(input int v, input bit sg);
      return (sg && v >= 128) ? longint'(v - 256) : longint'(v);
   endfunction

   // Plain matrix product of the model arrays, then clamp to the instance's output range.
   function automatic col_t model_col(input int d, input int t);
      col_t c;
      longint s, hi, lo, mask;
      int aw;
      bit sg;
      aw   = (d == 0) ? AW0 : ((d == 1) ? AW1 : AW2);
      sg   = (d == 1);
      hi   = sg ? (longint'(1) << (aw - 1)) - 1 : (longint'(1) << aw) - 1;
      lo   = sg ? -(longint'(1) << (aw - 1)) : 0;
      mask = (longint'(1) << aw) - 1;
      c.ov = 1'b0;
      for (int j = 0; j < DIM; j++) begin
         s = 0;
         for (int k = 0; k < DIM; k++) s += sx(model_w[j][k], sg) * sx(model_x[k][t], sg);
         if (s > hi) begin
            s = hi;
            c.ov = 1'b1;
         end else if (s < lo) begin
            s = lo;
            c.ov = 1'b1;
         end
         c.y[j] = s & mask;
      end
      return c;
   endfunction

   // Monitor: every column presented is popped and compared; between columns OUT_o must
   // hold the last expected column and OV_o must be 0.
   logic rst_seen = 1'b0;
   always @(posedge CLK) rst_seen <= RST;

   longint last_exp[3][DIM];
   longint m_g[DIM];
   col_t   m_c;
   bit     m_have;

   always @(negedge CLK) begin
      if (rst_seen) begin
         for (int d = 0; d < 3; d++) for (int j = 0; j < DIM; j++) last_exp[d][j] = 0;
      end
      for (int d = 0; d < 3; d++) begin
         for (int j = 0; j < DIM; j++) begin
            case (d)
               0:       m_g[j] = longint'(out0[(DIM-1-j)*AW0 +: AW0]);
               1:       m_g[j] = longint'(out1[(DIM-1-j)*AW1 +: AW1]);
               default: m_g[j] = longint'(out2[(DIM-1-j)*AW2 +: AW2]);
            endcase
         end
         if (val[d] === 1'b1) begin
            m_have = 1'b0;
            case (d)
               0:       if (q0.size() > 0) begin m_c = q0.pop_front(); m_have = 1'b1; end
               1:       if (q1.size() > 0) begin m_c = q1.pop_front(); m_have = 1'b1; end
               default: if (q2.size() > 0) begin m_c = q2.pop_front(); m_have = 1'b1; end
            endcase
            if (!m_have) begin
               checks++;
               failures++;
               $display("FAIL dut%0d_unexpected_col got VAL_o=1 required VAL_o=0 at %0t", d,
                        $time);
            end else begin
               for (int j = 0; j < DIM; j++) begin
                  chk($sformatf("dut%0d_y%0d", d, j), m_g[j], m_c.y[j]);
                  last_exp[d][j] = m_c.y[j];
               end
               chk($sformatf("dut%0d_ov", d), ov[d], m_c.ov);
            end
         end else begin
            chk($sformatf("dut%0d_ov_idle", d), ov[d], 0);
            for (int j = 0; j < DIM; j++)
               chk($sformatf("dut%0d_hold%0d", d, j), m_g[j], last_exp[d][j]);
         end
      end
   end

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic check_reset_vals(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s_rdy%0d", tag, d), rdy[d], 0);
         chk($sformatf("%s_val%0d", tag, d), val[d], 0);
         chk($sformatf("%s_ov%0d", tag, d), ov[d], 0);
         chk($sformatf("%s_busy%0d", tag, d), busy[d], 0);
         chk($sformatf("%s_done%0d", tag, d), done[d], 0);
      end
      chk({tag, "_out0"}, (out0 == '0), 1);
      chk({tag, "_out1"}, (out1 == '0), 1);
      chk({tag, "_out2"}, (out2 == '0), 1);
   endtask

   // wm/xm: 0 identity / 10*t+k, 1 constant, 2 random, 3 keep (W only)
   task automatic fill(input int wm, input int wv, input int xm, input int xv);
      for (int i = 0; i < DIM; i++)
         for (int k = 0; k < DIM; k++)
            case (wm)
               0:       model_w[i][k] = (i == k) ? 1 : 0;
               1:       model_w[i][k] = wv;
               2:       model_w[i][k] = int'($urandom_range(255));
               default: ;
            endcase
      for (int k = 0; k < DIM; k++)
         for (int t = 0; t < T; t++)
            case (xm)
               0:       model_x[k][t] = 10 * t + k;
               1:       model_x[k][t] = xv;
               default: model_x[k][t] = int'($urandom_range(255));
            endcase
   endtask

   task automatic send_beat(input logic [DIM*DW-1:0] d, input bit gap, input bit stray);
      if (gap) begin
         VAL_i  = 1'b0;
         DATA_i = {$urandom, $urandom};
         start  = stray;
         for (int i = 0; i < 3; i++) chk($sformatf("gap_rdy%0d", i), rdy[i], 1);
         tick();
      end
      VAL_i  = 1'b1;
      DATA_i = d;
      start  = stray;
      for (int i = 0; i < 3; i++) chk($sformatf("beat_rdy%0d", i), rdy[i], 1);
      tick();
   endtask

   task automatic run_job(input bit reuse, input bit gaps, input bit stray, input bit abort_job);
      logic [DIM*DW-1:0] beat;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("idle_rdy%0d", d), rdy[d], 0);
         chk($sformatf("idle_busy%0d", d), busy[d], 0);
      end
      start   = 1'b1;
      reuse_w = reuse;
      tick();
      start   = 1'b0;
      reuse_w = 1'b0;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("start_busy%0d", d), busy[d], 1);
         chk($sformatf("start_rdy%0d", d), rdy[d], 1);
      end
      if (!reuse) begin
         for (int i = 0; i < DIM; i++) begin
            for (int k = 0; k < DIM; k++) beat[(DIM-1-k)*DW +: DW] = 8'(model_w[i][k]);
            send_beat(beat, gaps && i > 0, 1'b0);
         end
      end
      for (int t = 0; t < T; t++) begin
         for (int k = 0; k < DIM; k++) beat[(DIM-1-k)*DW +: DW] = 8'(model_x[k][t]);
         send_beat(beat, gaps && t > 0, stray);
      end
      VAL_i = 1'b0;
      // Now in compute cycle 0.
      if (!abort_job) begin
         for (int t = 0; t < T; t++) begin
            q0.push_back(model_col(0, t));
            q1.push_back(model_col(1, t));
            q2.push_back(model_col(2, t));
         end
      end
      for (int c = 0; c <= 2 * DIM + T; c++) begin
         start = stray && c < 4;
         for (int d = 0; d < 3; d++) begin
            chk($sformatf("c%0d_val%0d", c, d), val[d], (c >= 2 * DIM && c < 2 * DIM + T));
            chk($sformatf("c%0d_done%0d", c, d), done[d], (c == 2 * DIM + T));
            chk($sformatf("c%0d_busy%0d", c, d), busy[d], (c < 2 * DIM + T));
            chk($sformatf("c%0d_rdy%0d", c, d), rdy[d], 0);
         end
         if (abort_job && c == 5) begin
            start = 1'b0;
            RST   = 1'b1;
            tick();
            check_reset_vals("abort");
            RST = 1'b0;
            for (int i = 0; i < DIM; i++) for (int k = 0; k < DIM; k++) model_w[i][k] = 0;
            return;
         end
         if (c < 2 * DIM + T) tick();
      end
      start = 1'b0;
   endtask

   initial begin
      bit r;
      repeat (3) tick();
      check_reset_vals("reset");
      RST = 1'b0;
      fill(0, 0, 0, 0);       run_job(1'b0, 1'b0, 1'b0, 1'b0);  // identity W
      fill(1, 255, 1, 255);   run_job(1'b0, 1'b0, 1'b0, 1'b0);  // all ones
      fill(1, 128, 1, 128);   run_job(1'b0, 1'b0, 1'b0, 1'b0);
      fill(1, 128, 1, 127);   run_job(1'b0, 1'b0, 1'b0, 1'b0);
      fill(0, 0, 0, 0);       run_job(1'b0, 1'b1, 1'b0, 1'b0);  // VAL_i gaps
      run_job(1'b1, 1'b0, 1'b0, 1'b0);                           // immediate reuse
      fill(2, 0, 2, 0);       run_job(1'b0, 1'b0, 1'b1, 1'b0);  // stray start pulses
      repeat (6) begin
         r = 1'($urandom_range(1));
         fill(r ? 3 : 2, 0, 2, 0);
         run_job(r, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0);
      end
      fill(2, 0, 2, 0);       run_job(1'b0, 1'b0, 1'b0, 1'b1);  // reset mid-compute
      fill(3, 0, 2, 0);       run_job(1'b1, 1'b0, 1'b0, 1'b0);  // W cleared by reset
      repeat (3) tick();
      chk("q0_drained", q0.size(), 0);
      chk("q1_drained", q1.size(), 0);
      chk("q2_drained", q2.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/systolic_matmul_stream.md
# systolic_matmul_stream

Parametrised weight-stationary systolic matrix multiplier: DIM×DIM grid of multiply-accumulate cells computing Y = W·X. W is DIM×DIM and X is DIM×T. Operands load over a valid/ready stream and results stream out one column per cycle with per-column saturation flags. Generalises the fixed 5×5 unsigned MAC array with configurable size, width and signedness, streamed loading with stalls, and a weight-reuse mode for back-to-back jobs on the same weights.

## Interface
- DIM, 5: array rows/columns (2..16)
- DW, 8: operand width
- T, 10: columns of X per job (1..255)
- ACCW, 2*DW+$clog2(DIM) = 19 with the defaults: output element width (DW+1..2*DW+$clog2(DIM))
- SIGNED, 0: 0 = unsigned operands, 1 = two's-complement operands
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- start  in  1  job start, sampled in IDLE only
- reuse_w  in  1  sampled with start; 1 = skip weight load, use stored W
- VAL_i  in  1  DATA_i beat valid
- DATA_i  in  DIM*DW  W row or X column; element k at [(DIM-1-k)*DW +: DW] (element 0 at MSB)
- RDY_o  out  1  block accepts a beat
- OUT_o  out  DIM*ACCW  Y column; row j at [(DIM-1-j)*ACCW +: ACCW]
- VAL_o  out  1  OUT_o/OV_o valid
- OV_o  out  1  at least one element of current column saturated
- BUSY_o  out  1  state ≠ IDLE
- DONE_o  out  1  one-cycle job-complete pulse

## Operation
- States: IDLE, LOAD_W, LOAD_X, COMPUTE.
- IDLE: start=1 → LOAD_X if reuse_w=1, else LOAD_W. start is ignored in every other state.
- LOAD_W: beat accepted when VAL_i & RDY_o. Beat i writes W row i. After DIM beats → LOAD_X.
- LOAD_X: accepted beat t writes X column t. After T beats → COMPUTE.
- VAL_i low in either load state stalls the load; the counters hold.
- COMPUTE: the FSM skews X into the array, accumulates across rows, and deskews the column results. It has no stalls.
- W registers persist across jobs and are cleared only by RST. reuse_w=1 after reset therefore computes with W = 0.
- Arithmetic: each product is full 2*DW bits, zero- or sign-extended per SIGNED.
  - Internal sums are 2*DW+$clog2(DIM) bits and exact.
  - The output saturates to ACCW bits: unsigned to 2^ACCW−1; signed to 2^(ACCW−1)−1 or −2^(ACCW−1).
  - OV_o = OR of the saturation events across the column's DIM elements.
- OUT_o holds the last emitted column when VAL_o=0. OV_o=0 whenever VAL_o=0.

## Timing
- Reset values: RDY_o=0, OUT_o=0, VAL_o=0, OV_o=0, BUSY_o=0, DONE_o=0, state IDLE, all W/X storage and counters 0.
- RST during any state aborts the job, and the next cycle meets all reset values.
- Cycle after start is sampled: BUSY_o=1 and RDY_o=1. RDY_o is high exactly in LOAD_W and LOAD_X.
- The beat that completes LOAD_X moves the state to COMPUTE on the next edge, and RDY_o drops the same cycle.
- Counting the first COMPUTE cycle as cycle 0:
  - VAL_o is high in cycles 2*DIM .. 2*DIM+T−1, Y column 0 first, with no gaps.
  - DONE_o is high in cycle 2*DIM+T.
  - The state is IDLE in cycle 2*DIM+T, so BUSY_o=0 and a new start is accepted that same cycle.
- Minimum job length: DIM+T load cycles + 2*DIM+T compute cycles (reuse_w=1 removes DIM).
- Data outputs (OUT_o, VAL_o, OV_o, DONE_o) are registered. RDY_o and BUSY_o are decoded from state only.

## Test plan
- Defaults, W = identity, X[k][t] = 10*t+k, VAL_i held high → OUT_o column t = X column t.
  - RDY_o high for 15 cycles.
  - VAL_o high in COMPUTE cycles 10..19, OV_o=0.
  - DONE_o in cycle 20.
- Unsigned, all operands 0xFF:
  - ACCW=19 → every element 325125 (0x4F605), OV_o=0.
  - ACCW=16 instance → every element 0xFFFF, OV_o=1 on all 10 columns.
- SIGNED=1, ACCW=16:
  - W = 0x80, X = 0x80 → 0x7FFF, OV_o=1.
  - W = 0x80, X = 0x7F → 0x8000, OV_o=1.
  - ACCW=19 with W = 0x80, X = 0x7F → −81280, OV_o=0.
- VAL_i toggling 1-0-1-0 during both loads, identity-W data → results identical to the first test, and load counters hold on gaps.
  - Immediate second start with reuse_w=1 → LOAD_X entered directly, RDY_o high 10 cycles, same results.
- Assert start during LOAD_X and COMPUTE → ignored, job completes unchanged.
- RST mid-COMPUTE (cycle 5) → next cycle VAL_o=0, BUSY_o=0, OUT_o=0.
  - Following start with reuse_w=1 → all outputs 0, OV_o=0.
